// File: rtl/exp_array_sequencer.sv
// exp_array_sequencer
// Sequences one systolic_array_exp instance over a tile of score columns:
// accepts a column, holds it on the array while doProcess runs for
// RUN_CYCLES, captures the per-row exp values and column sum, presents them
// downstream and keeps a running tile-wide exp sum.
//
// Optional build macro: EXP_CLEAR_BETWEEN_COLS_EN
//   Defined   -> a one-cycle CLEAR state after each input handshake pulses
//                arr_reset so the array starts every column from a clean state.
//   Undefined -> no CLEAR state; arr_reset only follows the module reset.
//
// state   | meaning
// IDLE    | waiting for a column (only state with in_ready high)
// CLEAR   | (macro only) one cycle of array reset before running
// RUN     | doProcess held high for RUN_CYCLES cycles
// CAPTURE | array outputs registered into the result registers
// HOLD    | result presented until downstream accepts it
module exp_array_sequencer #(
    parameter int N          = 4,
    parameter int K          = 4,
    parameter int RUN_CYCLES = K + N,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  real              in_data    [0:N-1],
    input  logic             in_last,
    output logic             arr_reset,
    output logic             arr_do_process,
    output real              arr_data   [0:N-1],
    input  real              arr_exp_in [0:N-1],
    input  real              arr_sum_in,
    output logic             out_valid,
    input  logic             out_ready,
    output real              out_exp    [0:N-1],
    output real              out_sum,
    output logic             out_last,
    output real              tile_sum,
    output logic [CNT_W-1:0] col_count,
    output logic             busy
);

    // A one-bit counter is kept even for RUN_CYCLES == 1 so the compare stays legal.
    localparam int CW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef EXP_CLEAR_BETWEEN_COLS_EN
        CLEAR,
`endif
        RUN,
        CAPTURE,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_q;
    logic          clr_q;

    // Handshake and activity flags are plain decodes of the state register.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Array reset follows the module reset, plus the CLEAR pulse when enabled.
    assign arr_reset = ~reset | clr_q;

    // Column sequencing FSM with all datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            last_q         <= 1'b0;
            clr_q          <= 1'b0;
            arr_do_process <= 1'b0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_sum        <= 0.0;
            tile_sum       <= 0.0;
            col_count      <= '0;
            for (int i = 0; i < N; i++) begin
                arr_data[i] <= 0.0;
                out_exp[i]  <= 0.0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            arr_data[i] <= in_data[i];
                        end
                        last_q <= in_last;
                        cnt    <= '0;
`ifdef EXP_CLEAR_BETWEEN_COLS_EN
                        clr_q  <= 1'b1;
                        state  <= CLEAR;
`else
                        arr_do_process <= 1'b1;
                        state          <= RUN;
`endif
                    end
                end
`ifdef EXP_CLEAR_BETWEEN_COLS_EN
                CLEAR: begin
                    clr_q          <= 1'b0;
                    arr_do_process <= 1'b1;
                    state          <= RUN;
                end
`endif
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        arr_do_process <= 1'b0;
                        state          <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < N; i++) begin
                        out_exp[i] <= arr_exp_in[i];
                    end
                    out_sum   <= arr_sum_in;
                    out_last  <= last_q;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        // The last column closes the tile; downstream reads
                        // tile_sum + out_sum at this handshake.
                        if (out_last) begin
                            col_count <= '0;
                            tile_sum  <= 0.0;
                        end else begin
                            col_count <= col_count + 1'b1;
                            tile_sum  <= tile_sum + out_sum;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
